// File: rtl/adc_scan_controller.sv
// Round-robin scan controller for a serial-config SAR ADC: drives CONV/SCK/SDI,
// shifts results in MSB first, and strobes each result with its channel number.
module adc_scan_controller #(
  parameter int DATA_W      = 12,
  parameter int NUM_CH      = 8,
  parameter int CONV_CYCLES = 80,
  parameter int SCK_DIV     = 2,
  parameter int TACQ_CYCLES = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              uni,
  output logic              adc_conv,
  output logic              adc_sck,
  output logic              adc_sdi,
  input  logic              adc_sdo,
  output logic [DATA_W-1:0] sample_data,
  output logic [2:0]        sample_ch,
  output logic              sample_valid,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_SHIFT, S_TACQ} state_t;

  localparam int CNT_MAX = (CONV_CYCLES > TACQ_CYCLES) ? CONV_CYCLES : TACQ_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int PH_W    = $clog2(2 * SCK_DIV + 1);
  localparam int BIT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_t            r_state, w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [PH_W-1:0]   r_ph;
  logic [BIT_W-1:0]  r_bit;
  logic [DATA_W-1:0] r_sr, w_sr_next, w_cfg;
  logic [2:0]        r_cur_ch, r_nch, w_nch, w_above, w_lowest;
  logic              r_uni, r_dummy, w_found_above;
  logic              w_conv_done, w_pulse_end, w_shift_done, w_tacq_done, w_cap, w_go;
  logic [DATA_W-1:0] r_sample_data;
  logic [2:0]        r_sample_ch;
  logic              r_sample_valid;

  assign w_go         = en && (ch_mask != '0);
  assign w_conv_done  = (r_state == S_CONV) && (r_cnt == CNT_W'(CONV_CYCLES - 1));
  assign w_pulse_end  = (r_ph == PH_W'(2 * SCK_DIV - 1));
  assign w_shift_done = (r_state == S_SHIFT) && w_pulse_end && (r_bit == BIT_W'(DATA_W - 1));
  assign w_tacq_done  = (r_state == S_TACQ) && (r_cnt == CNT_W'(TACQ_CYCLES - 1));
  assign w_cap        = (r_state == S_SHIFT) && (r_ph == PH_W'(SCK_DIV));
  assign w_sr_next    = w_cap ? {r_sr[DATA_W-2:0], adc_sdo} : r_sr;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_go) w_next = S_CONV;
      S_CONV:  if (w_conv_done) w_next = S_SHIFT;
      S_SHIFT: if (w_shift_done) w_next = S_TACQ;
      S_TACQ:  if (w_tacq_done) w_next = w_go ? S_CONV : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output logic: SDI holds its bit for the whole pulse since r_bit only moves at pulse end
  always_comb begin
    adc_conv = 1'b0;
    adc_sck  = 1'b0;
    adc_sdi  = 1'b0;
    busy     = (r_state != S_IDLE);
    case (r_state)
      S_CONV:  adc_conv = 1'b1;
      S_SHIFT: begin
        adc_sck = (r_ph >= PH_W'(SCK_DIV));
        adc_sdi = w_cfg[r_bit];
      end
      default: ;
    endcase
  end

  // Config word, bit k goes out during pulse k
  always_comb begin
    w_cfg    = '0;
    w_cfg[0] = 1'b1;
    w_cfg[1] = r_nch[0];
    w_cfg[2] = r_nch[2];
    w_cfg[3] = r_nch[1];
    w_cfg[4] = r_uni;
  end

  // Next channel: first set bit above the current one, else the lowest set bit
  always_comb begin
    w_above       = '0;
    w_lowest      = '0;
    w_found_above = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_mask[i]) begin
        w_lowest = 3'(i);
        if (!r_dummy && (3'(i) > r_cur_ch)) begin
          w_above       = 3'(i);
          w_found_above = 1'b1;
        end
      end
    end
    w_nch = w_found_above ? w_above : w_lowest;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_ph     <= '0;
      r_bit    <= '0;
      r_sr     <= '0;
      r_nch    <= '0;
      r_uni    <= 1'b0;
      r_cur_ch <= '0;
      r_dummy  <= 1'b1;
    end else begin
      r_cnt <= (r_state != w_next) ? '0 : r_cnt + 1'b1;
      r_sr  <= w_sr_next;
      if (r_state == S_SHIFT) begin
        r_ph <= w_pulse_end ? '0 : r_ph + 1'b1;
        if (w_pulse_end) r_bit <= r_bit + 1'b1;
      end else begin
        r_ph  <= '0;
        r_bit <= '0;
      end
      if (w_conv_done) begin
        r_nch <= w_nch;
        r_uni <= uni;
      end
      if (r_state == S_IDLE) r_dummy <= 1'b1;
      else if (w_shift_done) begin
        r_dummy  <= 1'b0;
        r_cur_ch <= r_nch;
      end
    end
  end

  // The result in the shifter belongs to the channel configured one frame earlier
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sample_data  <= '0;
      r_sample_ch    <= '0;
      r_sample_valid <= 1'b0;
    end else begin
      r_sample_valid <= 1'b0;
      if (w_shift_done && !r_dummy) begin
        r_sample_data  <= w_sr_next;
        r_sample_ch    <= r_cur_ch;
        r_sample_valid <= 1'b1;
      end
    end
  end

  assign sample_data  = r_sample_data;
  assign sample_ch    = r_sample_ch;
  assign sample_valid = r_sample_valid;

endmodule

// File: tb/tb_adc_scan_controller.sv
// Bench for adc_scan_controller: an ADC model drives SDO per frame while a
// channel/config scoreboard derived from the scan rules checks every frame.
module tb_adc_scan_controller;
  localparam int DW = 12, NC = 8, CC = 80, SD = 2, TA = 12;
  localparam int FRAME = CC + 2 * SD * DW + TA;

  logic          clk = 1'b0, rst, en, uni, adc_sdo;
  logic [NC-1:0] ch_mask;
  logic          adc_conv, adc_sck, adc_sdi, sample_valid, busy;
  logic [DW-1:0] sample_data;
  logic [2:0]    sample_ch;

  adc_scan_controller #(.DATA_W(DW), .NUM_CH(NC), .CONV_CYCLES(CC), .SCK_DIV(SD), .TACQ_CYCLES(TA)) dut (
    .clk(clk), .rst(rst), .en(en), .ch_mask(ch_mask), .uni(uni),
    .adc_conv(adc_conv), .adc_sck(adc_sck), .adc_sdi(adc_sdi), .adc_sdo(adc_sdo),
    .sample_data(sample_data), .sample_ch(sample_ch), .sample_valid(sample_valid), .busy(busy));

  always #5 clk = ~clk;

  int total = 0, bad = 0, g_cyc = 0, last_strobe = -1;
  logic [2:0]    m_cur = '0;
  logic          m_dummy = 1'b1;
  logic [DW-1:0] g_cfg;

  always @(posedge clk) g_cyc <= g_cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scan rule: walk upward from the channel after cur (from 0 on a dummy frame), wrapping
  function automatic logic [2:0] model_nch(input logic [NC-1:0] m, input logic [2:0] cur, input logic dummy);
    int start;
    start = dummy ? 0 : int'(cur) + 1;
    for (int d = 0; d < NC; d++) begin
      int c;
      c = (start + d) % NC;
      if (m[c]) return c[2:0];
    end
    return 3'd0;
  endfunction

  function automatic logic [DW-1:0] model_cfg(input logic [2:0] n, input logic u);
    logic [DW-1:0] w;
    w = '0;
    w[0] = 1'b1; w[1] = n[0]; w[2] = n[2]; w[3] = n[1]; w[4] = u;
    return w;
  endfunction

  // Runs one frame: returns at the negedge of the first TACQ cycle
  task automatic run_frame(input logic [NC-1:0] mask, input logic u, input logic [NC-1:0] mask_late,
                           input logic u_late, input logic [DW-1:0] val, input logic chk_gap, input logic drop_en);
    int n, lo, hi, lvl_bad, pulse_bad, vcnt, hold_bad;
    logic [DW-1:0] sdi_bits, d0;
    logic [2:0] nch, c0;
    logic b;
    ch_mask = mask; uni = u;
    n = 0; lvl_bad = 0; vcnt = 0; hold_bad = 0; pulse_bad = 0;
    d0 = sample_data; c0 = sample_ch;
    while (!adc_conv && n < 2 * FRAME) begin
      if (adc_sck || adc_sdi) lvl_bad++;
      if (n > 0 && sample_valid) vcnt++;
      if (sample_data !== d0 || sample_ch !== c0) hold_bad++;
      n++; @(negedge clk);
    end
    chk("conv_start", adc_conv, 1'b1);
    if (chk_gap) begin
      chk("tacq_len", n, TA);
      chk("strobe_one_cycle", vcnt, 0);
      chk("sample_hold", hold_bad, 0);
    end
    n = 0;
    while (adc_conv && n < 2 * CC) begin
      if (adc_sck || adc_sdi) lvl_bad++;
      if (drop_en && n == 10) en = 1'b0;
      n++; @(negedge clk);
    end
    chk("conv_len", n, CC);
    nch = model_nch(mask, m_cur, m_dummy);
    for (int k = 0; k < DW; k++) begin
      adc_sdo = val[DW-1-k];
      b = adc_sdi;
      sdi_bits[k] = b;
      lo = 0; hi = 0;
      while (!adc_sck && !adc_conv && lo < 4 * SD) begin
        if (adc_sdi !== b) lvl_bad++;
        lo++; @(negedge clk);
      end
      while (adc_sck && hi < 4 * SD) begin
        if (adc_sdi !== b || adc_conv) lvl_bad++;
        hi++; @(negedge clk);
      end
      if (lo != SD || hi != SD) pulse_bad++;
      if (k == 0) begin ch_mask = mask_late; uni = u_late; end
    end
    adc_sdo = 1'b0;
    g_cfg = sdi_bits;
    chk("sck_pulses", pulse_bad, 0);
    chk("adc_levels", lvl_bad, 0);
    chk("tacq_outputs", {adc_conv, adc_sck, adc_sdi, busy}, 4'b0001);
    chk("cfg_word", sdi_bits, model_cfg(nch, u));
    if (m_dummy) begin
      chk("dummy_no_strobe", sample_valid, 1'b0);
      last_strobe = -1;
    end else begin
      chk("strobe", sample_valid, 1'b1);
      chk("sample_ch", sample_ch, m_cur);
      chk("sample_data", sample_data, val);
      if (last_strobe >= 0) chk("strobe_gap", g_cyc - last_strobe, FRAME);
      last_strobe = g_cyc;
    end
    m_cur = nch;
    m_dummy = 1'b0;
  endtask

  initial begin
    int n, acc;
    logic [NC-1:0] rm;
    rst = 1'b1; en = 1'b0; ch_mask = '0; uni = 1'b0; adc_sdo = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_conv", adc_conv, 1'b0);
    chk("rst_sck", adc_sck, 1'b0);
    chk("rst_sdi", adc_sdi, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", sample_valid, 1'b0);
    chk("rst_data", sample_data, '0);
    chk("rst_ch", sample_ch, 3'd0);

    // Enabled with an empty mask must stay idle
    rst = 1'b0; en = 1'b1; acc = 0;
    repeat (20) begin @(negedge clk); if (busy || adc_conv) acc++; end
    chk("mask0_idle", acc, 0);

    // Two-channel scan with a fixed ADC result: dummy, then 0,2,0,2
    for (int f = 0; f < 5; f++) run_frame(8'h05, 1'b0, 8'h05, 1'b0, 12'hA5C, f > 0, 1'b0);
    chk("seq_last_ch", sample_ch, 3'd2);

    // Single channel 5, unipolar: config 1,1,1,0,1,0 then zeros
    run_frame(8'h20, 1'b1, 8'h20, 1'b1, DW'($urandom), 1'b1, 1'b0);
    chk("cfg_ch5_uni", g_cfg, 12'h017);

    // Random masks, with mask/uni changed mid-shift that must not leak into this frame
    for (int f = 0; f < 10; f++) begin
      rm = NC'($urandom_range(1, 255));
      run_frame(rm, 1'($urandom), NC'($urandom_range(1, 255)), 1'($urandom), DW'($urandom), 1'b1, 1'b0);
    end

    // en dropped during CONV: this frame still strobes, then idle
    run_frame(8'h96, 1'b0, 8'h96, 1'b0, DW'($urandom), 1'b1, 1'b1);
    repeat (TA) @(negedge clk);
    chk("idle_after_drop", busy, 1'b0);
    acc = 0;
    repeat (2 * FRAME) begin @(negedge clk); if (busy || adc_conv) acc++; end
    chk("no_conv_after_drop", acc, 0);

    // Reset in the middle of SHIFT
    ch_mask = 8'h3C; en = 1'b1; n = 0;
    while (!adc_conv && n < 20) begin n++; @(negedge clk); end
    n = 0;
    while (adc_conv && n < 2 * CC) begin n++; @(negedge clk); end
    repeat (7) @(negedge clk);
    chk("mid_shift_busy", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_shift", {adc_conv, adc_sck, adc_sdi, busy, sample_valid, sample_ch, sample_data}, '0);
    rst = 1'b0;
    m_dummy = 1'b1; m_cur = '0; last_strobe = -1;
    run_frame(8'h3C, 1'b0, 8'h3C, 1'b0, DW'($urandom), 1'b0, 1'b0);
    run_frame(8'h3C, 1'b1, 8'h3C, 1'b0, DW'($urandom), 1'b1, 1'b0);
    run_frame(8'h3C, 1'b0, 8'h3C, 1'b1, DW'($urandom), 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
